// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types, constants and helpers for the binary-to-BCD converter
// Contents: FSM state enum, BCD nibble width, and the largest representable
// decimal value for a given digit count (used by the optional overflow check,
// macro BIN2BCD_OVERFLOW_EN).
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_DONE
    } bcd_state_t;

    localparam int BCD_NIBBLE_W = 4;

    // 10^digits - 1, e.g. 9999 for four digits.
    function automatic logic [63:0] bcd_max_value(input int digits);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < digits; i++) begin
            r = r * 64'd10 + 64'd9;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble digit correction (add 3 when digit >= 5)
// Ports:
//   digit    in   4  BCD digit before correction
//   adjusted out  4  digit + 3 if digit >= 5, else digit (never exceeds 12)
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_NIBBLE_W-1:0] digit,
    output logic [BCD_NIBBLE_W-1:0] adjusted
);

    always_comb begin
        adjusted = digit;
        if (digit >= 4'd5) begin
            adjusted = digit + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_converter.sv
// rtl/bin_to_bcd_converter.sv - sequential shift-and-add-3 binary-to-BCD converter, one bit per clock
// Parameters: BIN_W (binary input width), DIGITS (BCD output digits)
// Ports:
//   CLK    in   1         system clock
//   RST    in   1         synchronous active-high reset
//   START  in   1         conversion request, sampled only in idle
//   BIN    in   BIN_W     unsigned value, latched when START is accepted
//   BCDOUT out  4*DIGITS  packed BCD result, [3:0] is the ones digit
//   DONE   out  1         one-cycle pulse in the cycle BCDOUT is updated
//   BUSY   out  1         high while converting or finishing
//   OVF    out  1         (only with BIN2BCD_OVERFLOW_EN) latched value exceeded 10^DIGITS-1
// Optional feature macro: BIN2BCD_OVERFLOW_EN saturates BCDOUT to all nines and raises OVF.
module bin_to_bcd_converter
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 4
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           START,
    input  logic [BIN_W-1:0]               BIN,
    output logic [BCD_NIBBLE_W*DIGITS-1:0] BCDOUT,
    output logic                           DONE,
    output logic                           BUSY
`ifdef BIN2BCD_OVERFLOW_EN
    ,
    output logic                           OVF
`endif
);

    localparam int ACC_W = BCD_NIBBLE_W * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    bcd_state_t       state;
    logic [BIN_W-1:0] bin_sh;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_adj;
    logic [CNT_W-1:0] cnt;

`ifdef BIN2BCD_OVERFLOW_EN
    localparam logic [63:0] BCD_MAX = bcd_max_value(DIGITS);
    // Decided at acceptance because the shift register is consumed by the conversion.
    logic ovf_pend;
`endif

    // Every digit is corrected in parallel before the shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (acc[g*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
            .adjusted (acc_adj[g*BCD_NIBBLE_W +: BCD_NIBBLE_W])
        );
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= ST_IDLE;
            bin_sh <= '0;
            acc    <= '0;
            cnt    <= '0;
            BCDOUT <= '0;
            DONE   <= 1'b0;
            BUSY   <= 1'b0;
`ifdef BIN2BCD_OVERFLOW_EN
            ovf_pend <= 1'b0;
            OVF      <= 1'b0;
`endif
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        bin_sh <= BIN;
                        acc    <= '0;
                        cnt    <= '0;
                        BUSY   <= 1'b1;
                        state  <= ST_CONVERT;
`ifdef BIN2BCD_OVERFLOW_EN
                        ovf_pend <= (64'(BIN) > BCD_MAX);
`endif
                    end
                end
                ST_CONVERT: begin
                    // Top accumulator bit falls off: modular result when out of range.
                    acc    <= {acc_adj[ACC_W-2:0], bin_sh[BIN_W-1]};
                    bin_sh <= {bin_sh[BIN_W-2:0], 1'b0};
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
`ifdef BIN2BCD_OVERFLOW_EN
                    BCDOUT <= ovf_pend ? {DIGITS{4'h9}} : acc;
                    OVF    <= ovf_pend;
`else
                    BCDOUT <= acc;
`endif
                    DONE   <= 1'b1;
                    BUSY   <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// tb/tb_bin_to_bcd_converter.sv - directed self-checking bench for bin_to_bcd_converter
module tb_bin_to_bcd_converter;

`ifdef BIN2BCD_OVERFLOW_EN
    localparam int BW = 14;
`else
    localparam int BW = 10;
`endif
    localparam int LAT = BW + 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic [BW-1:0] BIN = '0;
    logic [15:0]   BCDOUT;
    logic          DONE;
    logic          BUSY;
`ifdef BIN2BCD_OVERFLOW_EN
    logic          OVF;
`endif

    int checks = 0;
    int errors = 0;
    int cycle = 0;

    bin_to_bcd_converter #(.BIN_W(BW), .DIGITS(4)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .BIN    (BIN),
        .BCDOUT (BCDOUT),
        .DONE   (DONE),
        .BUSY   (BUSY)
`ifdef BIN2BCD_OVERFLOW_EN
        ,
        .OVF    (OVF)
`endif
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Wait for DONE; returns edges elapsed (0 if the bound expired).
    task automatic wait_done(input int bound, output int n);
        n = 0;
        for (int i = 1; i <= bound; i++) begin
            tick();
            if (DONE) begin
                n = i;
                break;
            end
        end
        check("done_seen", 32'(n != 0), 32'd1);
    endtask

    task automatic run_conv(input string tag, input logic [BW-1:0] val, input logic [15:0] exp);
        int n;
        BIN = val;
        START = 1'b1;
        tick();
        START = 1'b0;
        wait_done(40, n);
        check({tag, "_lat"}, 32'(n), 32'(LAT));
        check(tag, 32'(BCDOUT), 32'(exp));
    endtask

    typedef struct {
        int          val;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[10] = '{
        '{0, 16'h0000}, '{1, 16'h0001}, '{9, 16'h0009}, '{10, 16'h0010},
        '{99, 16'h0099}, '{100, 16'h0100}, '{999, 16'h0999}, '{1000, 16'h1000},
        '{1023, 16'h1023}, '{555, 16'h0555}
    };

    initial begin
        int n;
        int t_prev;
        int dones;
        int seq_val[3];
        logic [15:0] seq_exp[3];

        // Reset state
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        check("rst_bcd", 32'(BCDOUT), 32'h0);
        check("rst_done", 32'(DONE), 32'h0);
        check("rst_busy", 32'(BUSY), 32'h0);

        // BIN=0: DONE exactly one cycle, BUSY through conversion
        BIN = '0;
        START = 1'b1;
        tick();
        START = 1'b0;
        check("z_busy_start", 32'(BUSY), 32'h1);
        dones = 0;
        for (int i = 0; i < BW; i++) begin
            tick();
            if (DONE) dones++;
            if (!BUSY) dones += 100;
        end
        check("z_no_early_done", 32'(dones), 32'h0);
        tick();
        check("z_done", 32'(DONE), 32'h1);
        check("z_bcd", 32'(BCDOUT), 32'h0);
        check("z_busy_end", 32'(BUSY), 32'h0);
        tick();
        check("z_done_1cyc", 32'(DONE), 32'h0);

        // BIN changes after acceptance are ignored
        BIN = BW'(1023);
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        tick();
        BIN = BW'(5);
        wait_done(40, n);
        check("hold_lat", 32'(n + 2), 32'(LAT));
        check("hold_bcd", 32'(BCDOUT), 32'h1023);

        // Directed table
        foreach (vecs[i]) run_conv($sformatf("vec%0d", vecs[i].val), BW'(vecs[i].val), vecs[i].exp);

        // START held high: back-to-back results every BW+2 cycles
        seq_val = '{512, 999, 7};
        seq_exp = '{16'h0512, 16'h0999, 16'h0007};
        BIN = BW'(seq_val[0]);
        START = 1'b1;
        t_prev = -1;
        for (int i = 0; i < 3; i++) begin
            wait_done(40, n);
            check($sformatf("seq%0d", i), 32'(BCDOUT), 32'(seq_exp[i]));
            if (t_prev >= 0) check($sformatf("seq_gap%0d", i), 32'(cycle - t_prev), 32'(BW + 2));
            t_prev = cycle;
            if (i < 2) BIN = BW'(seq_val[i + 1]);
            else START = 1'b0;
        end
        tick();
        check("seq_idle", 32'(BUSY), 32'h0);
        tick();
        check("seq_hold", 32'(BCDOUT), 32'h0007);

        // START mid-conversion is ignored
        BIN = BW'(300);
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        tick();
        tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        wait_done(40, n);
        check("ign_lat", 32'(n + 4), 32'(LAT));
        check("ign_bcd", 32'(BCDOUT), 32'h0300);
        dones = 0;
        for (int i = 0; i < 2 * BW; i++) begin
            tick();
            if (DONE || BUSY) dones++;
        end
        check("ign_no_restart", 32'(dones), 32'h0);
        run_conv("ign_fresh", BW'(42), 16'h0042);

        // Reset mid-conversion aborts without a partial write
        run_conv("pre_rst", BW'(512), 16'h0512);
        BIN = BW'(845);
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("abort_bcd", 32'(BCDOUT), 32'h0);
        check("abort_busy", 32'(BUSY), 32'h0);
        dones = 0;
        for (int i = 0; i < 2 * BW; i++) begin
            tick();
            if (DONE || BUSY) dones++;
        end
        check("abort_quiet", 32'(dones), 32'h0);
        run_conv("abort_fresh", BW'(845), 16'h0845);

`ifdef BIN2BCD_OVERFLOW_EN
        run_conv("ovf_sat", BW'(12000), 16'h9999);
        check("ovf_flag", 32'(OVF), 32'h1);
        tick();
        check("ovf_hold", 32'(OVF), 32'h1);
        run_conv("ovf_max", BW'(9999), 16'h9999);
        check("ovf_clear", 32'(OVF), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
